// File: rtl/inst_buf_ctrl.sv
// Pointer/occupancy controller for the 32-entry fetch-to-decode instruction buffer.
// Optional perf counters are built when INST_BUF_CTRL_PERF_EN is defined.
//
// state | meaning
// IDLE  | buffer empty, waiting for a fetch bundle
// RUN   | entries present, room for a full bundle
// STALL | too full for a full bundle; decode keeps draining
// FLUSH | one-cycle drain after flush_i; nothing accepted or presented
module inst_buf_ctrl #(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5,
  parameter int WR_W  = 8,
  parameter int RD_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             fetch_vld_i,
  input  logic [WR_W-1:0]  fetch_mask_i,
  output logic             fetch_rdy_o,
  output logic             buf_wr_en_o,
  output logic [PTR_W-1:0] buf_wr_ptr_o,
  output logic [3:0]       buf_wr_cnt_o,
  output logic             dec_vld_o,
  input  logic             dec_rdy_i,
  output logic [PTR_W-1:0] buf_rd_ptr_o,
  output logic [2:0]       buf_rd_cnt_o,
  output logic [PTR_W:0]   buf_cnt_o,
  output logic             buf_full_o,
  output logic             buf_empty_o
`ifdef INST_BUF_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_fetch_stall_o,
  output logic [31:0]      perf_dec_starve_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_FLUSH} state_e;

  localparam logic [PTR_W:0]   CNT_TH = (PTR_W+1)'(DEPTH - WR_W);
  localparam logic [PTR_W+1:0] NXT_TH = (PTR_W+2)'(DEPTH - WR_W);
  localparam logic [PTR_W:0]   RD_MAX = (PTR_W+1)'(RD_W);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic [PTR_W+1:0]   cnt_sum;
  logic               wr_acc;
  logic [3:0]         wr_n;
  logic [2:0]         rd_avail;
  logic [2:0]         rd_n;

  // Non-thermometer masks are treated as popcount lanes starting at lane 0.
  function automatic logic [3:0] popcnt(input logic [WR_W-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < WR_W; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE:  if (cnt_sum != '0) state_d = S_RUN;
        S_RUN: begin
          if (cnt_sum == '0)         state_d = S_IDLE;
          else if (cnt_sum > NXT_TH) state_d = S_STALL;
        end
        S_STALL: begin
          if (cnt_sum == '0)          state_d = S_IDLE;
          else if (cnt_sum <= NXT_TH) state_d = S_RUN;
        end
        S_FLUSH: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshakes are held low while reset is asserted.
  always_comb begin
    fetch_rdy_o = !reset && !flush_i && (state_q != S_FLUSH) && (cnt_q <= CNT_TH);
    dec_vld_o   = !reset && !flush_i && (state_q != S_FLUSH) && (cnt_q != '0);
  end

  always_comb begin
    wr_acc       = fetch_vld_i && fetch_rdy_o;
    wr_n         = wr_acc ? popcnt(fetch_mask_i) : 4'd0;
    buf_wr_en_o  = wr_acc && (wr_n != 4'd0);
    buf_wr_cnt_o = wr_n;
    rd_avail     = (cnt_q < RD_MAX) ? cnt_q[2:0] : 3'(RD_W);
    buf_rd_cnt_o = dec_vld_o ? rd_avail : 3'd0;
    rd_n         = (dec_vld_o && dec_rdy_i) ? buf_rd_cnt_o : 3'd0;
    cnt_sum      = {1'b0, cnt_q} + (PTR_W+2)'(wr_n) - (PTR_W+2)'(rd_n);
  end

  always_comb begin
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_n);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_n);
      cnt_d    = cnt_sum[PTR_W:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign buf_wr_ptr_o = wr_ptr_q;
  assign buf_rd_ptr_o = rd_ptr_q;
  assign buf_cnt_o    = cnt_q;
  assign buf_full_o   = cnt_q > CNT_TH;
  assign buf_empty_o  = cnt_q == '0;

`ifdef INST_BUF_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_starve_q;

  // Saturating; flush intentionally leaves them alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_q  <= '0;
      perf_starve_q <= '0;
    end else begin
      if (fetch_vld_i && !fetch_rdy_o && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (dec_rdy_i && !dec_vld_o && (perf_starve_q != '1))
        perf_starve_q <= perf_starve_q + 32'd1;
    end
  end

  assign perf_fetch_stall_o = perf_stall_q;
  assign perf_dec_starve_o  = perf_starve_q;
`endif

endmodule

// File: tb/tb_inst_buf_ctrl.sv
// Scoreboard bench for inst_buf_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_inst_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       fvld = 1'b0;
  logic [7:0] fmask = 8'h00;
  logic       drdy = 1'b0;
  logic       frdy, wen, dvld, full, empty;
  logic [4:0] wptr, rptr;
  logic [3:0] wcnt;
  logic [2:0] rcnt;
  logic [5:0] cnt;
`ifdef INST_BUF_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_starve;
`endif

  inst_buf_ctrl dut (
    .clock(clk), .reset(rst), .flush_i(flush),
    .fetch_vld_i(fvld), .fetch_mask_i(fmask), .fetch_rdy_o(frdy),
    .buf_wr_en_o(wen), .buf_wr_ptr_o(wptr), .buf_wr_cnt_o(wcnt),
    .dec_vld_o(dvld), .dec_rdy_i(drdy), .buf_rd_ptr_o(rptr), .buf_rd_cnt_o(rcnt),
    .buf_cnt_o(cnt), .buf_full_o(full), .buf_empty_o(empty)
`ifdef INST_BUF_CTRL_PERF_EN
    , .perf_fetch_stall_o(perf_stall), .perf_dec_starve_o(perf_starve)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       frdy, wen;
    logic [3:0] wcnt;
    logic [4:0] wptr;
    logic       dvld;
    logic [2:0] rcnt;
    logic [4:0] rptr;
    logic [5:0] cnt;
    logic       full, empty;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   tests = 0;
  int   fails = 0;
  int   vid = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = '{frdy, wen, wcnt, wptr, dvld, rcnt, rptr, cnt, full, empty};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL vec%0d got rdy=%0b wen=%0b wc=%0d wp=%0d dv=%0b rc=%0d rp=%0d cnt=%0d full=%0b empty=%0b | want rdy=%0b wen=%0b wc=%0d wp=%0d dv=%0b rc=%0d rp=%0d cnt=%0d full=%0b empty=%0b",
                 id, a.frdy, a.wen, a.wcnt, a.wptr, a.dvld, a.rcnt, a.rptr, a.cnt, a.full, a.empty,
                 e.frdy, e.wen, e.wcnt, e.wptr, e.dvld, e.rcnt, e.rptr, e.cnt, e.full, e.empty);
      end
    end
  end

  task automatic d(input logic r, input logic f, input logic vl, input logic [7:0] m, input logic dr);
    @(posedge clk);
    #1;
    rst = r; flush = f; fvld = vl; fmask = m; drdy = dr;
  endtask

  task automatic v(input logic r, input logic f, input logic vl, input logic [7:0] m, input logic dr,
                   input logic e_frdy, input logic e_wen, input int e_wcnt, input int e_wptr,
                   input logic e_dvld, input int e_rcnt, input int e_rptr, input int e_cnt,
                   input logic e_full, input logic e_empty);
    exp_t e;
    d(r, f, vl, m, dr);
    e = '{e_frdy, e_wen, 4'(e_wcnt), 5'(e_wptr), e_dvld, 3'(e_rcnt), 5'(e_rptr), 6'(e_cnt), e_full, e_empty};
    exp_q.push_back(e);
    id_q.push_back(vid);
    vid++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  initial begin
    // reset holds everything idle even with requests present
    v(1,0,1,8'hFF,1, 0,0,0,0,  0,0,0,  0,0,1);
    // fill 8,16,24,32 with decode stalled
    v(0,0,1,8'hFF,0, 1,1,8,0,  0,0,0,  0,0,1);
    v(0,0,1,8'hFF,0, 1,1,8,8,  1,4,0,  8,0,0);
    v(0,0,1,8'hFF,0, 1,1,8,16, 1,4,0, 16,0,0);
    v(0,0,1,8'hFF,0, 1,1,8,24, 1,4,0, 24,0,0);
    v(0,0,1,8'hFF,0, 0,0,0,0,  1,4,0, 32,1,0);
    // drain by 4 per cycle; fetch ready returns at 24
    v(0,0,0,8'h00,1, 0,0,0,0,  1,4,0, 32,1,0);
    v(0,0,0,8'h00,1, 0,0,0,0,  1,4,4, 28,1,0);
    v(0,0,0,8'h00,1, 1,0,0,0,  1,4,8, 24,0,0);
    v(0,0,0,8'h00,1, 1,0,0,0,  1,4,12,20,0,0);
    v(0,0,0,8'h00,1, 1,0,0,0,  1,4,16,16,0,0);
    v(0,0,0,8'h00,1, 1,0,0,0,  1,4,20,12,0,0);
    v(0,0,0,8'h00,1, 1,0,0,0,  1,4,24, 8,0,0);
    v(0,0,0,8'h00,1, 1,0,0,0,  1,4,28, 4,0,0);
    v(0,0,0,8'h00,1, 1,0,0,0,  0,0,0,  0,0,1);
    // count 2, then write 3 while reading 2
    v(0,0,1,8'h03,1, 1,1,2,0,  0,0,0,  0,0,1);
    v(0,0,1,8'h07,1, 1,1,3,2,  1,2,0,  2,0,0);
    // non-thermometer mask counts lanes
    v(0,0,1,8'hA1,0, 1,1,3,5,  1,3,2,  3,0,0);
    // empty mask accepted but no write strobe
    v(0,0,1,8'h00,1, 1,0,0,8,  1,4,2,  6,0,0);
    v(0,0,0,8'h00,1, 1,0,0,8,  1,2,6,  2,0,0);
    // steer write pointer to 28 with count 0
    v(0,0,1,8'hFF,1, 1,1,8,8,  0,0,8,  0,0,1);
    v(0,0,1,8'hFF,1, 1,1,8,16, 1,4,8,  8,0,0);
    v(0,0,1,8'h0F,1, 1,1,4,24, 1,4,12,12,0,0);
    v(0,0,0,8'h00,1, 1,0,0,28, 1,4,16,12,0,0);
    v(0,0,0,8'h00,1, 1,0,0,28, 1,4,20, 8,0,0);
    v(0,0,0,8'h00,1, 1,0,0,28, 1,4,24, 4,0,0);
    // wrap: write at 28 lands wr_ptr at 4, read from 28 wraps to 0
    v(0,0,1,8'hFF,1, 1,1,8,28, 0,0,28, 0,0,1);
    v(0,0,0,8'h00,1, 1,0,0,4,  1,4,28, 8,0,0);
    v(0,0,1,8'hFF,0, 1,1,8,4,  1,4,0,  4,0,0);
    // flush at count 12 drops both transfers, then one FLUSH cycle
    v(0,1,1,8'hFF,1, 0,0,0,12, 0,0,0, 12,0,0);
    v(0,0,1,8'hFF,1, 0,0,0,0,  0,0,0,  0,0,1);
    v(0,0,1,8'hFF,0, 1,1,8,0,  0,0,0,  0,0,1);
    // flush during FLUSH restarts it
    v(0,1,1,8'hFF,1, 0,0,0,8,  0,0,0,  8,0,0);
    v(0,1,1,8'hFF,1, 0,0,0,0,  0,0,0,  0,0,1);
    v(0,0,1,8'hFF,1, 0,0,0,0,  0,0,0,  0,0,1);
    v(0,0,1,8'hFF,0, 1,1,8,0,  0,0,0,  0,0,1);
    // reset mid-operation
    v(1,0,1,8'hFF,1, 0,0,0,0,  0,0,0,  0,0,1);
    v(0,0,0,8'h00,0, 1,0,0,0,  0,0,0,  0,0,1);

`ifdef INST_BUF_CTRL_PERF_EN
    for (int i = 0; i < 4; i++) d(0,0,1,8'hFF,0);
    for (int i = 0; i < 5; i++) d(0,0,1,8'hFF,0);
    d(0,0,0,8'h00,0);
    @(negedge clk); #1;
    chk("perf_stall_5", perf_stall, 32'd5);
    chk("perf_starve_0", perf_starve, 32'd0);
    d(0,1,0,8'h00,0);
    d(0,0,0,8'h00,0);
    @(negedge clk); #1;
    chk("perf_stall_flush", perf_stall, 32'd5);
    d(1,0,0,8'h00,0);
    @(negedge clk); #1;
    chk("perf_stall_reset", perf_stall, 32'd0);
    d(0,0,0,8'h00,0);
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
